// File: rtl/cache_control_nway_if.sv
// Bundle of the CPU request, physical-memory and datapath-control signals
// around the N-way cache controller. The controller uses the slave side;
// the CPU/datapath/memory environment uses the master side.
interface cache_control_nway_if #(
  parameter int NUM_WAYS = 4,
  parameter int CNT_W    = 32
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  // environment -> controller
  logic                mem_read;
  logic                mem_write;
  logic                pmem_resp;
  logic [NUM_WAYS-1:0] hit_vec;
  logic [NUM_WAYS-1:0] valid_vec;
  logic [NUM_WAYS-1:0] dirty_vec;
  logic [NUM_WAYS-2:0] plru_in;

  // controller -> environment
  logic                mem_resp;
  logic                pmem_read;
  logic                pmem_write;
  logic                pmem_addr_sel;
  logic                data_in_sel;
  logic [NUM_WAYS-1:0] data_we;
  logic [NUM_WAYS-1:0] tag_load;
  logic [NUM_WAYS-1:0] valid_load;
  logic [NUM_WAYS-1:0] dirty_load;
  logic                dirty_in;
  logic                plru_load;
  logic [NUM_WAYS-2:0] plru_out;
  logic [WAY_W-1:0]    way_sel;
  logic [CNT_W-1:0]    hit_count;
  logic [CNT_W-1:0]    miss_count;

  modport slave (
    input  mem_read, mem_write, pmem_resp, hit_vec, valid_vec, dirty_vec, plru_in,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel,
           data_we, tag_load, valid_load, dirty_load, dirty_in,
           plru_load, plru_out, way_sel, hit_count, miss_count
  );

  modport master (
    output mem_read, mem_write, pmem_resp, hit_vec, valid_vec, dirty_vec, plru_in,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel,
           data_we, tag_load, valid_load, dirty_load, dirty_in,
           plru_load, plru_out, way_sel, hit_count, miss_count
  );
endinterface

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative, write-back, write-allocate cache.
// Picks a victim (first invalid way, else tree-PLRU), writes back dirty
// victims, fills, then re-probes. Keeps saturating hit/miss counters.
module cache_control_nway #(
  parameter int NUM_WAYS = 4,
  parameter int CNT_W    = 32
) (
  input logic                 clk,
  input logic                 rst,
  cache_control_nway_if.slave bus
);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int NODE_W = WAY_W + 1;  // addresses every node of the tree incl. leaves

  typedef enum logic [1:0] {IDLE, TAG_CHECK, WRITEBACK, FILL} state_e;

  state_e              state_q, state_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic                retry_q, retry_d;
  logic [CNT_W-1:0]    hit_count_q, hit_count_d;
  logic [CNT_W-1:0]    miss_count_q, miss_count_d;

  logic                hit, is_write, any_free;
  logic [WAY_W-1:0]    hit_way, free_way, plru_way, miss_way;
  logic [NUM_WAYS-2:0] plru_upd;
  logic [2*NUM_WAYS-1:0] tree;
  logic [NODE_W-1:0]   node;

  assign hit      = |bus.hit_vec;
  // a simultaneous read and write is serviced as a read
  assign is_write = bus.mem_write & ~bus.mem_read;
  assign miss_way = any_free ? free_way : plru_way;

  // hit-way index and lowest-index invalid way
  always_comb begin
    hit_way  = '0;
    free_way = '0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++)
      if (bus.hit_vec[i]) hit_way = WAY_W'(i);
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (!bus.valid_vec[i]) begin
        free_way = WAY_W'(i);
        any_free = 1'b1;
      end
  end

  // PLRU victim walk from the root: 0 goes left, 1 goes right
  always_comb begin
    tree = '0;
    tree[NUM_WAYS-2:0] = bus.plru_in;
    node = '0;
    for (int l = 0; l < WAY_W; l++)
      node = (node << 1) + NODE_W'(1) + NODE_W'(tree[node]);
    plru_way = WAY_W'(node - NODE_W'(NUM_WAYS - 1));
  end

  // PLRU access update: the level-l node on the hit way's path is
  // (2^l - 1) + (way >> (WAY_W - l)); point it away from the accessed child
  always_comb begin
    plru_upd = bus.plru_in;
    for (int i = 0; i < NUM_WAYS - 1; i++)
      for (int l = 0; l < WAY_W; l++)
        if (i == (1 << l) - 1 + int'(hit_way >> (WAY_W - l)))
          plru_upd[i] = ~hit_way[WAY_W-1-l];
  end

  // state, victim, retry flag and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      retry_q      <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      retry_q      <= retry_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // next-state, victim latch and counter updates
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    retry_d      = retry_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    case (state_q)
      IDLE:
        if (bus.mem_read || bus.mem_write) state_d = TAG_CHECK;
      TAG_CHECK:
        if (hit) begin
          state_d = IDLE;
          retry_d = 1'b0;
          // re-probes after a fill are not first-probe hits
          if (!retry_q && !(&hit_count_q)) hit_count_d = hit_count_q + CNT_W'(1);
        end else begin
          victim_d = miss_way;
          retry_d  = 1'b1;
          if (!(&miss_count_q)) miss_count_d = miss_count_q + CNT_W'(1);
          state_d = (bus.valid_vec[miss_way] && bus.dirty_vec[miss_way]) ? WRITEBACK : FILL;
        end
      WRITEBACK:
        if (bus.pmem_resp) state_d = FILL;
      FILL:
        if (bus.pmem_resp) state_d = TAG_CHECK;
      default: state_d = IDLE;
    endcase
  end

  // datapath / memory strobes, all decoded from state and inputs
  always_comb begin
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.data_in_sel   = 1'b0;
    bus.data_we       = '0;
    bus.tag_load      = '0;
    bus.valid_load    = '0;
    bus.dirty_load    = '0;
    bus.dirty_in      = 1'b0;
    bus.plru_load     = 1'b0;
    bus.plru_out      = '0;
    bus.way_sel       = '0;
    case (state_q)
      TAG_CHECK:
        if (hit) begin
          bus.mem_resp  = 1'b1;
          bus.way_sel   = hit_way;
          bus.plru_load = 1'b1;
          bus.plru_out  = plru_upd;
          if (is_write) begin
            bus.data_we    = NUM_WAYS'(1) << hit_way;
            bus.dirty_load = NUM_WAYS'(1) << hit_way;
            bus.dirty_in   = 1'b1;
          end
        end
      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        bus.way_sel       = victim_q;
        if (bus.pmem_resp) bus.dirty_load = NUM_WAYS'(1) << victim_q;
      end
      FILL: begin
        bus.pmem_read   = 1'b1;
        bus.data_in_sel = 1'b1;
        bus.way_sel     = victim_q;
        if (bus.pmem_resp) begin
          bus.data_we    = NUM_WAYS'(1) << victim_q;
          bus.tag_load   = NUM_WAYS'(1) << victim_q;
          bus.valid_load = NUM_WAYS'(1) << victim_q;
          bus.dirty_load = NUM_WAYS'(1) << victim_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
endmodule

// File: tb/tb_cache_control_nway.sv
// Bench for cache_control_nway: the bench plays CPU, datapath (one set of
// tags/valid/dirty/PLRU) and memory. A transaction-level model predicts the
// cycle-by-cycle outputs; a negedge process compares them.
module tb_cache_control_nway;
  localparam int NW = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_control_nway_if #(.NUM_WAYS(NW), .CNT_W(CW)) bus();
  cache_control_nway #(.NUM_WAYS(NW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // set model
  logic [NW-1:0] s_valid, s_dirty;
  logic [NW-2:0] s_plru;
  int            s_tag[NW];
  int            m_hits, m_misses;

  // expected outputs for the current cycle
  logic        exp_vld;
  logic [31:0] e_mem_resp, e_pmem_read, e_pmem_write, e_addr_sel, e_din_sel;
  logic [31:0] e_data_we, e_tag_load, e_valid_load, e_dirty_load, e_dirty_in;
  logic [31:0] e_plru_load, e_plru_out, e_way_sel, e_hc, e_mc;

  // values captured on the most recent mem_resp
  int          lat_cnt, last_lat;
  logic [31:0] last_plru, last_we, last_dl, last_din, last_way;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // victim by halving the way range from the root
  function automatic int plru_victim(input logic [NW-2:0] t);
    int lo = 0, size = NW, nd = 0;
    while (size > 1) begin
      if (t[nd]) begin lo += size / 2; nd = 2 * nd + 2; end
      else nd = 2 * nd + 1;
      size /= 2;
    end
    return lo;
  endfunction

  // mark way w most recently used: path nodes point to the other half
  function automatic logic [NW-2:0] plru_touch(input logic [NW-2:0] t, input int w);
    int lo = 0, size = NW, nd = 0, half;
    while (size > 1) begin
      half = size / 2;
      if (w < lo + half) begin t[nd] = 1'b1; nd = 2 * nd + 1; end
      else begin t[nd] = 1'b0; lo += half; nd = 2 * nd + 2; end
      size = half;
    end
    return t;
  endfunction

  function automatic logic [NW-1:0] hits(input int tag);
    logic [NW-1:0] h = '0;
    for (int i = 0; i < NW; i++) if (s_valid[i] && s_tag[i] == tag) h[i] = 1'b1;
    return h;
  endfunction

  function automatic int hv_idx(input logic [NW-1:0] h);
    for (int i = 0; i < NW; i++) if (h[i]) return i;
    return 0;
  endfunction

  function automatic int pick_victim();
    for (int i = 0; i < NW; i++) if (!s_valid[i]) return i;
    return plru_victim(s_plru);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_set(input logic [NW-1:0] hv);
    bus.hit_vec   = hv;
    bus.valid_vec = s_valid;
    bus.dirty_vec = s_dirty;
    bus.plru_in   = s_plru;
  endtask

  task automatic exp_zero();
    exp_vld = 1'b1;
    e_mem_resp = 0; e_pmem_read = 0; e_pmem_write = 0; e_addr_sel = 0; e_din_sel = 0;
    e_data_we = 0; e_tag_load = 0; e_valid_load = 0; e_dirty_load = 0; e_dirty_in = 0;
    e_plru_load = 0; e_plru_out = 0; e_way_sel = 0;
    e_hc = 32'(m_hits); e_mc = 32'(m_misses);
  endtask

  task automatic idle(input int n);
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    for (int k = 0; k < n; k++) begin
      drive_set(hits($urandom_range(0, 5)));
      bus.pmem_resp = 1'($urandom_range(0, 1));
      exp_zero();
      tick();
    end
  endtask

  task automatic do_reset();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
    rst = 1'b1; exp_vld = 1'b0;
    tick();
    rst = 1'b0; m_hits = 0; m_misses = 0;
  endtask

  // One CPU transaction. wbw/flw = memory wait cycles before pmem_resp;
  // abort_at >= 0 pulses rst in that writeback cycle.
  task automatic do_txn(input bit rd, input bit wr, input int tag,
                        input int wbw, input int flw, input int abort_at);
    bit is_wr, retry;
    logic [NW-1:0] hv;
    int v, w;
    is_wr = wr && !rd;
    retry = 1'b0;
    bus.mem_read = rd; bus.mem_write = wr;
    drive_set(hits(tag)); bus.pmem_resp = 1'($urandom_range(0, 1)); exp_zero();
    tick();
    for (int p = 0; p < 2; p++) begin
      hv = hits(tag);
      drive_set(hv); bus.pmem_resp = 1'($urandom_range(0, 1)); exp_zero();
      if (hv != '0) begin
        w = hv_idx(hv);
        e_mem_resp = 1; e_way_sel = 32'(w); e_plru_load = 1;
        e_plru_out = 32'(plru_touch(s_plru, w));
        if (is_wr) begin e_data_we = 32'(1) << w; e_dirty_load = 32'(1) << w; e_dirty_in = 1; end
        tick();
        s_plru = plru_touch(s_plru, w);
        if (is_wr) s_dirty[w] = 1'b1;
        if (!retry) m_hits = sat(m_hits);
        break;
      end
      v = pick_victim();
      tick();
      m_misses = sat(m_misses);
      retry = 1'b1;
      if (s_valid[v] && s_dirty[v]) begin
        for (int k = 0; k <= wbw; k++) begin
          drive_set(hv); bus.pmem_resp = (k == wbw); exp_zero();
          e_pmem_write = 1; e_addr_sel = 1; e_way_sel = 32'(v);
          if (k == wbw) e_dirty_load = 32'(1) << v;
          if (k == abort_at) begin
            rst = 1'b1; bus.pmem_resp = 1'b0; exp_vld = 1'b0;
            tick();
            rst = 1'b0; m_hits = 0; m_misses = 0;
            bus.mem_read = 1'b0; bus.mem_write = 1'b0;
            return;
          end
          tick();
        end
        s_dirty[v] = 1'b0;
      end
      for (int k = 0; k <= flw; k++) begin
        drive_set(hv); bus.pmem_resp = (k == flw); exp_zero();
        e_pmem_read = 1; e_din_sel = 1; e_way_sel = 32'(v);
        if (k == flw) begin
          e_data_we = 32'(1) << v; e_tag_load = 32'(1) << v;
          e_valid_load = 32'(1) << v; e_dirty_load = 32'(1) << v;
        end
        tick();
      end
      s_valid[v] = 1'b1; s_dirty[v] = 1'b0; s_tag[v] = tag;
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  task automatic load_full_set(input logic [NW-1:0] dirty);
    s_valid = '1; s_dirty = dirty; s_plru = '0;
    s_tag = '{10, 11, 12, 13};
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (rst) lat_cnt = 0;
    else if (exp_vld) begin
      chk("mem_resp",      32'(bus.mem_resp),      e_mem_resp);
      chk("pmem_read",     32'(bus.pmem_read),     e_pmem_read);
      chk("pmem_write",    32'(bus.pmem_write),    e_pmem_write);
      chk("pmem_addr_sel", 32'(bus.pmem_addr_sel), e_addr_sel);
      chk("data_in_sel",   32'(bus.data_in_sel),   e_din_sel);
      chk("data_we",       32'(bus.data_we),       e_data_we);
      chk("tag_load",      32'(bus.tag_load),      e_tag_load);
      chk("valid_load",    32'(bus.valid_load),    e_valid_load);
      chk("dirty_load",    32'(bus.dirty_load),    e_dirty_load);
      chk("dirty_in",      32'(bus.dirty_in),      e_dirty_in);
      chk("plru_load",     32'(bus.plru_load),     e_plru_load);
      chk("plru_out",      32'(bus.plru_out),      e_plru_out);
      chk("way_sel",       32'(bus.way_sel),       e_way_sel);
      chk("hit_count",     32'(bus.hit_count),     e_hc);
      chk("miss_count",    32'(bus.miss_count),    e_mc);
      if (bus.mem_resp) begin
        last_lat = lat_cnt; lat_cnt = 0;
        last_plru = 32'(bus.plru_out); last_we = 32'(bus.data_we);
        last_dl = 32'(bus.dirty_load); last_din = 32'(bus.dirty_in);
        last_way = 32'(bus.way_sel);
      end else if (bus.mem_read || bus.mem_write) lat_cnt++;
    end
  end

  initial begin
    exp_vld = 1'b0; lat_cnt = 0; last_lat = 0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
    s_valid = '0; s_dirty = '0; s_plru = '0; s_tag = '{-1, -1, -1, -1};
    m_hits = 0; m_misses = 0;
    drive_set('0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_hit_count", 32'(bus.hit_count), 32'd0);
    chk("reset_miss_count", 32'(bus.miss_count), 32'd0);
    idle(2);

    // cold read: fill way 0, re-probe hits, 1-cycle memory
    do_txn(1, 0, 1, 0, 1, -1);
    chk("cold_latency", 32'(last_lat), 32'd4);
    chk("cold_way", last_way, 32'd0);
    chk("cold_miss_count", 32'(bus.miss_count), 32'd1);
    chk("cold_hit_count", 32'(bus.hit_count), 32'd0);
    idle(1);

    // all valid & clean, plru 000: victim way 0, no writeback
    load_full_set('0);
    do_txn(1, 0, 20, 0, 0, -1);
    chk("clean_victim_way", last_way, 32'd0);
    chk("clean_reprobe_plru", last_plru, 32'b011);
    chk("clean_read_we", last_we, 32'd0);
    idle(1);

    // dirty victim, write miss: writeback, fill, write-hit merge
    load_full_set('1);
    do_txn(0, 1, 20, 2, 1, -1);
    chk("wb_write_we", last_we, 32'b0001);
    chk("wb_write_dirty_in", last_din, 32'd1);
    idle(1);

    // write hits with plru 000 on ways 2 and 3
    load_full_set('0);
    do_txn(0, 1, 12, 0, 0, -1);
    chk("hit2_we", last_we, 32'b0100);
    chk("hit2_dirty_load", last_dl, 32'b0100);
    chk("hit2_plru", last_plru, 32'b100);
    s_plru = '0;
    do_txn(0, 1, 13, 0, 0, -1);
    chk("hit3_we", last_we, 32'b1000);
    chk("hit3_plru", last_plru, 32'b000);
    idle(1);

    // reset in the middle of a writeback
    load_full_set('1);
    do_txn(1, 0, 21, 3, 0, 1);
    chk("abort_pmem_write", 32'(bus.pmem_write), 32'd0);
    chk("abort_hit_count", 32'(bus.hit_count), 32'd0);
    chk("abort_miss_count", 32'(bus.miss_count), 32'd0);
    idle(1);
    do_txn(1, 0, 21, 1, 1, -1);
    chk("after_abort_way", last_way, 32'd0);
    chk("after_abort_miss", 32'(bus.miss_count), 32'd1);
    idle(1);

    // read and write together on a hit behave as a read; then saturate
    do_txn(1, 1, 11, 0, 0, -1);
    chk("rw_both_we", last_we, 32'd0);
    chk("rw_both_dirty_load", last_dl, 32'd0);
    for (int k = 0; k < 20; k++) do_txn(1, 0, 11, 0, 0, -1);
    chk("hit_saturate", 32'(bus.hit_count), 32'd15);
    idle(1);

    // randomized traffic on one set
    for (int t = 0; t < 250; t++) begin
      int op;
      if ($urandom_range(0, 15) == 0) do_reset();
      op = int'($urandom_range(0, 2));
      do_txn(op != 1, op != 0, int'($urandom_range(0, 5)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      idle(int'($urandom_range(0, 2)));
    end

    exp_vld = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
